// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: four requesters share one WIDTH-bit 4:1 mux feeding a single
// registered output stage. Round-robin arbitration with burst (packet) locking.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - synchronous active-low reset
//   in_valid   - [i] requester i presents a beat
//   in_data    - requester i data at [i*WIDTH +: WIDTH]
//   in_last    - [i] requester i's beat ends its burst
//   in_ready   - [i] requester i's beat accepted this cycle (combinational, one-hot or zero)
//   out_valid  - registered beat available
//   out_data   - registered data
//   out_last   - registered last flag
//   out_src    - index of the requester that supplied the registered beat
//   out_ready  - downstream accepts the registered beat this cycle
module rr_mux_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic [3:0]         in_last,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [1:0]         out_src,
    input  logic               out_ready
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDXW = 2;

    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic             lock_q, lock_d;
    logic [IDXW-1:0]  lock_id_q, lock_id_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [IDXW-1:0]  out_src_q, out_src_d;

    logic [WIDTH-1:0] data_arr [NREQ];
    logic [IDXW-1:0]  cand;
    logic [IDXW-1:0]  idx;
    logic             found;
    logic             load_ok;
    logic             xfer;

    // Split the flat data bus into one word per requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Candidate: burst owner while locked, else first valid from ptr+1 onward.
    // k = NREQ wraps to ptr itself, so the last-granted requester is searched last.
    always_comb begin
        cand  = lock_id_q;
        idx   = '0;
        found = 1'b0;
        if (!lock_q) begin
            cand = ptr_q;
            for (int unsigned k = 1; k <= NREQ; k++) begin
                idx = ptr_q + IDXW'(k);
                if (!found && in_valid[idx]) begin
                    cand  = idx;
                    found = 1'b1;
                end
            end
        end
    end

    // Grant, transfer and next-state for pointer, lock and output register.
    always_comb begin
        load_ok     = ~out_valid_q | out_ready;
        in_ready    = '0;
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        lock_id_d   = lock_id_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;

        if (rst_n && load_ok && in_valid[cand]) begin
            in_ready[cand] = 1'b1;
        end
        xfer = |in_ready;

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = data_arr[cand];
            out_last_d  = in_last[cand];
            out_src_d   = cand;
            ptr_d       = cand;
            lock_d      = ~in_last[cand];
            if (!in_last[cand]) begin
                lock_id_d = cand;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; ptr resets to 3 so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= 2'd3;
            lock_q      <= 1'b0;
            lock_id_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            lock_id_q   <= lock_id_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule
